btb_assoc: RTL and testbench

Parametrised N-way set-associative successor to the direct-mapped BTB, serving the IF stage with a combinational lookup and training from the EX stage.
- Each entry holds a 2-bit hysteresis counter; one taken→not-taken flip no longer discards a target.
- Replacement is tree pseudo-LRU.
- Valid bits are cleared by a multi-cycle sweep FSM after reset or flush, replacing the large single-cycle array reset.

---
 rtl/btb_pkg.sv | 19 +
 rtl/btb_plru.sv | 40 ++++
 rtl/btb_assoc.sv | 145 ++++++++++++++
 tb/tb_btb_assoc.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared entry layout, counter encodings and sweep FSM states for btb_assoc.
package btb_pkg;
    // Tag and target fields are sized for the widest supported address (ADDR_WIDTH <= 64).
    localparam int BTB_MAX_W = 64;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic                 valid;
        logic [BTB_MAX_W-1:0] tag;
        logic [BTB_MAX_W-1:0] target;
        logic [1:0]           ctr;
    } entry_t;
endpackage

// File: rtl/btb_plru.sv
// btb_plru: tree pseudo-LRU for one set; picks a victim and computes bits after touching a way.
module btb_plru #(
    parameter int WAYS = 2,
    localparam int LW = WAYS > 1 ? $clog2(WAYS) : 1,
    localparam int PW = WAYS > 1 ? WAYS - 1 : 1
) (
    input  logic [PW-1:0]   bits,
    input  logic [WAYS-1:0] valid,
    input  logic [LW-1:0]   touch,
    output logic [LW-1:0]   victim,
    output logic [PW-1:0]   next_bits
);
    localparam int IW = PW > 1 ? $clog2(PW) : 1;
    localparam int TW = LW > 1 ? $clog2(LW) : 1;
    if (WAYS == 1) begin : g_direct
        assign victim = '0;
        assign next_bits = bits;
    end else begin : g_tree
        int   vnode;
        int   tnode;
        logic d;
        // Heap-ordered tree: node n lives in bits[n-1]; a bit of 1 steers the victim right.
        always_comb begin
            vnode = 1;
            for (int l = 0; l < LW; l++) vnode = 2 * vnode + int'(bits[IW'(vnode - 1)]);
            victim = LW'(vnode - WAYS);
            for (int w = WAYS - 1; w >= 0; w--) victim = valid[w] ? victim : LW'(w);
        end
        always_comb begin
            next_bits = bits;
            tnode = 1;
            d = 1'b0;
            for (int l = 0; l < LW; l++) begin
                d = touch[TW'(LW - 1 - l)];
                next_bits[IW'(tnode - 1)] = ~d;
                tnode = 2 * tnode + int'(d);
            end
        end
    end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: N-way set-associative BTB with hysteresis counters, tree PLRU and a valid-clearing sweep.
// Define BTB_PERF_EN to add perf_lookups/perf_hits/perf_allocs counters.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int WAYS        = 2,
    parameter int OFFSET_BITS = 2,
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    output logic [ADDR_WIDTH-1:0] predicted_target,
    output logic                  hit,
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  branch_taken_ex,
    input  logic [ADDR_WIDTH-1:0] target_addr_ex,
    output logic                  ready
`ifdef BTB_PERF_EN
    ,
    output logic [31:0]           perf_lookups,
    output logic [31:0]           perf_hits,
    output logic [31:0]           perf_allocs
`endif
);
    localparam int SETS = 1 << INDEX_WIDTH;
    localparam int LW   = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int PW   = WAYS > 1 ? WAYS - 1 : 1;
    localparam int TLO  = OFFSET_BITS + INDEX_WIDTH;

    entry_t                 mem [SETS][WAYS];
    logic [PW-1:0]          plru [SETS];
    state_t                 state;
    logic [INDEX_WIDTH-1:0] sweep_idx;

    logic [INDEX_WIDTH-1:0] if_idx, ex_idx;
    logic [TAG_WIDTH-1:0]   if_tag, ex_tag;
    logic                   run, fwd, arr_hit, ex_hit, upd, alloc;
    logic [BTB_MAX_W-1:0]   arr_tgt;
    logic [LW-1:0]          hw, victim, touch;
    logic [WAYS-1:0]        vvec;
    logic [PW-1:0]          next_bits;
    logic [1:0]             hc, ctr_inc, ctr_dec;

    assign run    = state == RUN;
    assign if_idx = pc_if[TLO-1:OFFSET_BITS];
    assign if_tag = pc_if[ADDR_WIDTH-1:TLO];
    assign ex_idx = pc_ex[TLO-1:OFFSET_BITS];
    assign ex_tag = pc_ex[ADDR_WIDTH-1:TLO];

    always_comb begin
        arr_hit = 1'b0;
        arr_tgt = '0;
        for (int w = 0; w < WAYS; w++)
            if (mem[if_idx][w].valid && mem[if_idx][w].tag == BTB_MAX_W'(if_tag) && mem[if_idx][w].ctr[1]) begin
                arr_hit = 1'b1;
                arr_tgt = mem[if_idx][w].target;
            end
    end

    // Same-cycle EX training of the fetched PC overrides the array.
    assign fwd = run && if_req && ex_valid && branch_taken_ex && pc_if == pc_ex;
    assign hit = fwd || (run && if_req && arr_hit);
    assign predicted_target = fwd ? target_addr_ex : hit ? ADDR_WIDTH'(arr_tgt) : '0;

    always_comb begin
        ex_hit = 1'b0;
        hw = '0;
        for (int w = 0; w < WAYS; w++) begin
            vvec[w] = mem[ex_idx][w].valid;
            if (mem[ex_idx][w].valid && mem[ex_idx][w].tag == BTB_MAX_W'(ex_tag)) begin
                ex_hit = 1'b1;
                hw = LW'(w);
            end
        end
    end

    assign hc      = mem[ex_idx][hw].ctr;
    assign ctr_inc = hc == CTR_ST ? CTR_ST : hc + 2'd1;
    assign ctr_dec = hc == CTR_SNT ? CTR_SNT : hc - 2'd1;
    assign upd     = run && ex_valid && !flush && !reset;
    assign alloc   = upd && !ex_hit && branch_taken_ex;
    assign touch   = ex_hit ? hw : victim;

    btb_plru #(.WAYS(WAYS)) u_plru (
        .bits(plru[ex_idx]),
        .valid(vvec),
        .touch(touch),
        .victim(victim),
        .next_bits(next_bits)
    );

    // Array storage has no reset; only valid and PLRU bits are cleared, one set per sweep cycle.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int w = 0; w < WAYS; w++) mem[sweep_idx][w].valid <= 1'b0;
            plru[sweep_idx] <= '0;
        end else if (upd && ex_hit) begin
            if (branch_taken_ex) begin
                mem[ex_idx][hw].ctr <= ctr_inc;
                mem[ex_idx][hw].target <= BTB_MAX_W'(target_addr_ex);
                plru[ex_idx] <= next_bits;
            end else begin
                mem[ex_idx][hw].ctr <= ctr_dec;
                if (ctr_dec == CTR_SNT) mem[ex_idx][hw].valid <= 1'b0;
            end
        end else if (alloc) begin
            mem[ex_idx][victim] <= '{valid: 1'b1, tag: BTB_MAX_W'(ex_tag), target: BTB_MAX_W'(target_addr_ex), ctr: CTR_WT};
            plru[ex_idx] <= next_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= INIT;
            sweep_idx <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            sweep_idx <= sweep_idx + 1'b1;
            if (&sweep_idx) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

`ifdef BTB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_lookups <= '0;
            perf_hits <= '0;
            perf_allocs <= '0;
        end else begin
            if (run && if_req) perf_lookups <= perf_lookups + 32'd1;
            if (hit) perf_hits <= perf_hits + 32'd1;
            if (alloc) perf_allocs <= perf_allocs + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed self-checking bench for btb_assoc (default parameters, 2 ways, 64 sets).
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        reset, flush, if_req, ex_valid, branch_taken_ex, hit, ready;
    logic [63:0] pc_if, pc_ex, target_addr_ex, predicted_target;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cnt;
`ifdef BTB_PERF_EN
    logic [31:0] perf_lookups, perf_hits, perf_allocs;
`endif

    btb_assoc dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .if_req(if_req),
        .pc_if(pc_if),
        .predicted_target(predicted_target),
        .hit(hit),
        .ex_valid(ex_valid),
        .pc_ex(pc_ex),
        .branch_taken_ex(branch_taken_ex),
        .target_addr_ex(target_addr_ex),
        .ready(ready)
`ifdef BTB_PERF_EN
        ,
        .perf_lookups(perf_lookups),
        .perf_hits(perf_hits),
        .perf_allocs(perf_allocs)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt);
        if_req = 1'b0;
        ex_valid = 1'b1;
        pc_ex = pc;
        branch_taken_ex = tk;
        target_addr_ex = tgt;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic [63:0] pc, input logic eh, input logic [63:0] et);
        if_req = 1'b1;
        pc_if = pc;
        #1;
        chk({tag, ".hit"}, 64'(hit), 64'(eh));
        chk({tag, ".tgt"}, predicted_target, et);
        if_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; if_req = 1'b0; ex_valid = 1'b0;
        branch_taken_ex = 1'b0; pc_if = '0; pc_ex = '0; target_addr_ex = '0;
        step();
        step();
        reset = 1'b0;
        look("init_lookup", 64'h1000, 1'b0, 64'h0);
        // Sweep: count cycles with ready low; an update mid-sweep must be dropped.
        cnt = 0;
        while (!ready && cnt < 300) begin
            cnt++;
            if (cnt == 10) upd(64'h7000, 1'b1, 64'h7100);
            else step();
        end
        chk("reset_sweep_len", 64'(cnt), 64'd64);
        chk("ready_after_reset", 64'(ready), 64'd1);
        look("init_update_dropped", 64'h7000, 1'b0, 64'h0);
        // Allocate and hit.
        upd(64'h1000, 1'b1, 64'h2000);
        look("alloc_hit", 64'h1000, 1'b1, 64'h2000);
        look("neighbour_miss", 64'h1004, 1'b0, 64'h0);
        // Hysteresis: 2 -> 1 -> 2 -> 1 -> 0 (invalid), then a fresh allocation.
        upd(64'h1000, 1'b0, 64'h0);
        look("weak_nt", 64'h1000, 1'b0, 64'h0);
        upd(64'h1000, 1'b1, 64'h2000);
        look("back_to_wt", 64'h1000, 1'b1, 64'h2000);
        upd(64'h1000, 1'b0, 64'h0);
        upd(64'h1000, 1'b0, 64'h0);
        upd(64'h1000, 1'b1, 64'h2222);
        look("realloc_after_invalid", 64'h1000, 1'b1, 64'h2222);
        // Conflict in set 0: A way0, B way1, touch A, C evicts B.
        upd(64'h2000, 1'b1, 64'h2100);
        look("b_alloc", 64'h2000, 1'b1, 64'h2100);
        upd(64'h1000, 1'b1, 64'h1111);
        upd(64'h3000, 1'b1, 64'h3100);
        look("conflict_a", 64'h1000, 1'b1, 64'h1111);
        look("conflict_c", 64'h3000, 1'b1, 64'h3100);
        look("conflict_b_evicted", 64'h2000, 1'b0, 64'h0);
        // Forwarding in the training cycle; next cycle the array holds it (evicting A).
        if_req = 1'b1; pc_if = 64'h5000;
        ex_valid = 1'b1; pc_ex = 64'h5000; branch_taken_ex = 1'b1; target_addr_ex = 64'h6000;
        #1;
        chk("fwd.hit", 64'(hit), 64'd1);
        chk("fwd.tgt", predicted_target, 64'h6000);
        step();
        ex_valid = 1'b0;
        look("fwd_stored", 64'h5000, 1'b1, 64'h6000);
        look("a_evicted_by_fwd", 64'h1000, 1'b0, 64'h0);
        if_req = 1'b1; pc_if = 64'h9000;
        ex_valid = 1'b1; pc_ex = 64'h9000; branch_taken_ex = 1'b0; target_addr_ex = 64'h9900;
        #1;
        chk("no_fwd_not_taken", 64'(hit), 64'd0);
        step();
        ex_valid = 1'b0; if_req = 1'b0;
        // Flush with a concurrent taken update, then a second flush mid-sweep restarts it.
        flush = 1'b1;
        ex_valid = 1'b1; pc_ex = 64'hA000; branch_taken_ex = 1'b1; target_addr_ex = 64'hA100;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        chk("ready_after_flush", 64'(ready), 64'd0);
        cnt = 0;
        while (!ready && cnt < 300) begin
            cnt++;
            flush = cnt == 20;
            step();
            flush = 1'b0;
        end
        chk("flush_sweep_len", 64'(cnt), 64'd84);
        look("flush_c_miss", 64'h3000, 1'b0, 64'h0);
        look("flush_fwd_miss", 64'h5000, 1'b0, 64'h0);
        look("flush_update_dropped", 64'hA000, 1'b0, 64'h0);
        upd(64'h1000, 1'b1, 64'h4444);
        look("post_flush_alloc", 64'h1000, 1'b1, 64'h4444);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
